mod_check_serializer: RTL and testbench

- Transmit-side counterpart of the team's serial MSB-first divisibility checkers.
- Accepts a parallel WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first on a 1-bit serial line.
- After the data bits, appends a CHK-bit check field chosen so the whole frame, read as one binary number, is an exact multiple of MOD.
- Feeding the frame into the downstream mod-MOD checker leaves that checker in its remainder-0 state after the last check bit.

---
 rtl/mod_check_serializer_if.sv | 25 ++
 rtl/mod_check_serializer.sv | 171 +++++++++++++++++
 tb/tb_mod_check_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_check_serializer_if.sv
// Word-in / bit-out interface of the check serializer.
// The slave modport is the serializer itself; the master modport is the word source and frame sink.
interface mod_check_serializer_if #(
   parameter int WIDTH = 8,
   parameter int CHK   = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             dout;
   logic             dout_valid;
   logic             frame_first;
   logic             frame_last;
   logic [CHK-1:0]   rem_out;

   modport slave (
      input  in_valid, in_data,
      output in_ready, dout, dout_valid, frame_first, frame_last, rem_out
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, dout, dout_valid, frame_first, frame_last, rem_out
   );
endinterface

// File: rtl/mod_check_serializer.sv
// Shifts a parallel word out MSB-first, then appends a CHK-bit check field
// that makes the whole frame an exact multiple of MOD.
module mod_check_serializer #(
   parameter  int WIDTH = 8,
   parameter  int MOD   = 5,
   localparam int CHK   = $clog2(MOD)
) (
   input logic                   clk,
   input logic                   resetn,
   mod_check_serializer_if.slave bus
);

   localparam int CNT_MAX = (WIDTH > CHK) ? WIDTH : CHK;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CHK:0] L_MOD = (CHK+1)'(MOD);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_CHECK
   } state_t;

   // Appending bit b to a value with remainder rem: {rem, b} is exactly 2*rem+b,
   // which stays below 2*MOD, so a single conditional subtract reduces it.
   function automatic logic [CHK-1:0] f_step(input logic [CHK-1:0] rem, input logic bit_in);
      logic [CHK:0] w_sum;
      w_sum = {rem, bit_in};
      if (w_sum >= L_MOD) w_sum = w_sum - L_MOD;
      return w_sum[CHK-1:0];
   endfunction

   // Check value: the negation of (R * 2^CHK) mod MOD, so frame mod MOD == 0.
   function automatic logic [CHK-1:0] f_check(input logic [CHK-1:0] rem);
      logic [CHK-1:0] w_r;
      logic [CHK:0]   w_diff;
      w_r = rem;
      for (int k = 0; k < CHK; k++) w_r = f_step(w_r, 1'b0);
      w_diff = L_MOD - {1'b0, w_r};
      if (w_r == '0) w_diff = '0;
      return w_diff[CHK-1:0];
   endfunction

   state_t           r_state,  w_state_nxt;
   logic [WIDTH-1:0] r_shift,  w_shift_nxt;
   logic [CHK-1:0]   r_chk,    w_chk_nxt;
   logic [CW-1:0]    r_cnt,    w_cnt_nxt;
   logic [CHK-1:0]   r_rem,    w_rem_nxt;
   logic             r_dout,   w_dout_nxt;
   logic             r_valid,  w_valid_nxt;
   logic             r_first,  w_first_nxt;
   logic             r_last,   w_last_nxt;

   logic             w_in_ready;
   logic             w_xfer;
   logic [CHK-1:0]   w_chk_val;

   // Ready depends only on state so the source never sees a valid->ready loop.
   assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_CHECK) && r_last);
   assign w_xfer     = bus.in_valid && w_in_ready;
   assign w_chk_val  = f_check(r_rem);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_chk_nxt   = r_chk;
      w_cnt_nxt   = r_cnt;
      w_rem_nxt   = r_rem;
      w_dout_nxt  = r_dout;
      w_valid_nxt = r_valid;
      w_first_nxt = 1'b0;
      w_last_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_valid_nxt = 1'b0;
            w_dout_nxt  = 1'b0;
            if (w_xfer) begin
               w_state_nxt = S_DATA;
               w_dout_nxt  = bus.in_data[WIDTH-1];
               w_shift_nxt = bus.in_data << 1;
               w_cnt_nxt   = CW'(1);
               w_rem_nxt   = f_step('0, bus.in_data[WIDTH-1]);
               w_valid_nxt = 1'b1;
               w_first_nxt = 1'b1;
            end
         end

         S_DATA: begin
            if (r_cnt == CW'(WIDTH)) begin
               w_state_nxt = S_CHECK;
               w_dout_nxt  = w_chk_val[CHK-1];
               w_chk_nxt   = w_chk_val << 1;
               w_cnt_nxt   = CW'(1);
               w_rem_nxt   = f_step(r_rem, w_chk_val[CHK-1]);
               w_last_nxt  = (CHK == 1);
            end else begin
               w_dout_nxt  = r_shift[WIDTH-1];
               w_shift_nxt = r_shift << 1;
               w_cnt_nxt   = r_cnt + CW'(1);
               w_rem_nxt   = f_step(r_rem, r_shift[WIDTH-1]);
            end
         end

         S_CHECK: begin
            if (r_last) begin
               // Final check bit is on the line; a new word may start with no gap.
               if (w_xfer) begin
                  w_state_nxt = S_DATA;
                  w_dout_nxt  = bus.in_data[WIDTH-1];
                  w_shift_nxt = bus.in_data << 1;
                  w_cnt_nxt   = CW'(1);
                  w_rem_nxt   = f_step('0, bus.in_data[WIDTH-1]);
                  w_valid_nxt = 1'b1;
                  w_first_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_dout_nxt  = 1'b0;
                  w_valid_nxt = 1'b0;
                  w_cnt_nxt   = '0;
               end
            end else begin
               w_dout_nxt  = r_chk[CHK-1];
               w_chk_nxt   = r_chk << 1;
               w_cnt_nxt   = r_cnt + CW'(1);
               w_rem_nxt   = f_step(r_rem, r_chk[CHK-1]);
               w_last_nxt  = (r_cnt == CW'(CHK-1));
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
            w_dout_nxt  = 1'b0;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_chk   <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_dout  <= 1'b0;
         r_valid <= 1'b0;
         r_first <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_chk   <= w_chk_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rem   <= w_rem_nxt;
         r_dout  <= w_dout_nxt;
         r_valid <= w_valid_nxt;
         r_first <= w_first_nxt;
         r_last  <= w_last_nxt;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.dout        = r_dout;
   assign bus.dout_valid  = r_valid;
   assign bus.frame_first = r_first;
   assign bus.frame_last  = r_last;
   assign bus.rem_out     = r_rem;

endmodule

// File: tb/tb_mod_check_serializer.sv
// Directed and randomised checks of mod_check_serializer at WIDTH=8, MOD=5 (11-bit frames).
module tb_mod_check_serializer;

   localparam int WIDTH = 8;
   localparam int MOD   = 5;
   localparam int CHK   = 3;
   localparam int FLEN  = WIDTH + CHK;
   localparam int N_RND = 1000;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_fail;

   mod_check_serializer_if #(.WIDTH(WIDTH), .CHK(CHK)) bus ();

   mod_check_serializer #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at the negedge of a frame's first bit cycle; samples ncyc cycles of output.
   task automatic collect(input int ncyc, input logic [31:0] exp_bits,
                          input logic [7:0] next_data, input string tag);
      logic [31:0] got_bits, got_first, got_last, exp_first, exp_last;
      int n_valid, n_rdy_low, rem_err, rem_m, nfr;
      logic eb;
      nfr = ncyc / FLEN;
      got_bits = '0; got_first = '0; got_last = '0;
      exp_first = '0; exp_last = '0;
      n_valid = 0; n_rdy_low = 0; rem_err = 0; rem_m = 0;
      for (int f = 0; f < nfr; f++) begin
         exp_first[ncyc-1-FLEN*f]    = 1'b1;
         exp_last[ncyc-FLEN-FLEN*f]  = 1'b1;
      end
      for (int i = 0; i < ncyc; i++) begin
         got_bits  = {got_bits[30:0],  bus.dout};
         got_first = {got_first[30:0], bus.frame_first};
         got_last  = {got_last[30:0],  bus.frame_last};
         if (bus.dout_valid) n_valid++;
         if (!bus.in_ready) n_rdy_low++;
         if (i % FLEN == 0) rem_m = 0;
         eb = exp_bits[ncyc-1-i];
         rem_m = (2 * rem_m + int'(eb)) % MOD;
         if (int'(bus.rem_out) != rem_m) rem_err++;
         if (i == 0) bus.in_data = next_data;
         if (i == ncyc - 1) bus.in_valid = 1'b0;
         @(negedge clk);
      end
      check({tag, ".bits"},     got_bits,  exp_bits);
      check({tag, ".first"},    got_first, exp_first);
      check({tag, ".last"},     got_last,  exp_last);
      check({tag, ".valid_n"},  n_valid,   ncyc);
      check({tag, ".rdy_low"},  n_rdy_low, ncyc - nfr);
      check({tag, ".rem_err"},  rem_err,   0);
      check({tag, ".idle_vld"}, bus.dout_valid, 1'b0);
   endtask

   // Presents a word at a negedge while idle; returns at the negedge of data bit 0.
   task automatic start(input logic [7:0] d, input string tag);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      check({tag, ".rdy"}, bus.in_ready, 1'b1);
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [2:0] chk;
      string      tag;
   } vec_t;

   vec_t vecs[5];

   logic [7:0] sb[$];
   int         n_rx;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      resetn       = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      vecs[0] = '{8'h01, 3'b010, "v01"};
      vecs[1] = '{8'h07, 3'b100, "v07"};
      vecs[2] = '{8'h80, 3'b001, "v80"};
      vecs[3] = '{8'h00, 3'b000, "v00"};
      vecs[4] = '{8'hFF, 3'b000, "vFF"};

      repeat (3) @(negedge clk);
      check("rst.dout",  bus.dout,        1'b0);
      check("rst.valid", bus.dout_valid,  1'b0);
      check("rst.first", bus.frame_first, 1'b0);
      check("rst.last",  bus.frame_last,  1'b0);
      check("rst.rem",   bus.rem_out,     3'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("rst.ready", bus.in_ready, 1'b1);

      // Single frames; in_data is scrambled after capture and in_valid held while busy.
      foreach (vecs[k]) begin
         start(vecs[k].data, vecs[k].tag);
         collect(FLEN, {21'd0, vecs[k].data, vecs[k].chk}, ~vecs[k].data, vecs[k].tag);
      end

      // Back-to-back: second word waits with valid high and is taken on the frame_last cycle.
      start(8'h01, "b2b");
      collect(2 * FLEN, {10'd0, 8'h01, 3'b010, 8'h07, 3'b100}, 8'h07, "b2b");

      // Reset during data bit 4 with in_valid held.
      start(8'hA5, "mid");
      repeat (4) @(negedge clk);
      check("mid.bit4", bus.dout, 1'b0);
      resetn = 1'b0;
      @(negedge clk);
      check("mid.valid", bus.dout_valid, 1'b0);
      check("mid.rem",   bus.rem_out,    3'd0);
      check("mid.ready", bus.in_ready,   1'b1);
      resetn      = 1'b1;
      bus.in_data = 8'h07;
      @(negedge clk);
      collect(FLEN, {21'd0, 8'h07, 3'b100}, 8'h00, "post");

      // Random words with random gaps; scoreboard checks data and divisibility.
      n_rx = 0;
      fork
         begin : driver
            int gap, waited;
            logic [7:0] w;
            for (int k = 0; k < N_RND; k++) begin
               gap = $urandom_range(0, 3);
               repeat (gap) @(negedge clk);
               w = 8'($urandom_range(0, 255));
               bus.in_valid = 1'b1;
               bus.in_data  = w;
               waited = 0;
               while (!bus.in_ready && waited < 100) begin
                  @(negedge clk);
                  waited++;
               end
               if (waited >= 100) begin
                  check("rnd.stall", waited, 0);
                  bus.in_valid = 1'b0;
                  break;
               end
               sb.push_back(w);
               @(negedge clk);
               bus.in_valid = 1'b0;
            end
         end
         begin : monitor
            int cycles, len;
            logic [31:0] fr;
            logic [7:0]  e;
            cycles = 0; len = 0; fr = '0;
            while (n_rx < N_RND && cycles < 40000) begin
               @(negedge clk);
               cycles++;
               if (bus.dout_valid) begin
                  if (bus.frame_first) begin
                     fr  = '0;
                     len = 0;
                  end
                  fr = {fr[30:0], bus.dout};
                  len++;
                  if (bus.frame_last) begin
                     if (sb.size() == 0) begin
                        check("rnd.sb_empty", sb.size(), 1);
                        e = '0;
                     end else begin
                        e = sb.pop_front();
                     end
                     check("rnd.data", fr >> CHK, {24'd0, e});
                     check("rnd.mod",  fr % MOD, 0);
                     check("rnd.len",  len, FLEN);
                     check("rnd.rem",  bus.rem_out, 3'd0);
                     n_rx++;
                  end
               end
            end
            if (n_rx < N_RND) check("rnd.timeout", n_rx, N_RND);
         end
      join

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
